// File: rtl/uart_rx_frame_decoder_if.sv
// Bundle between one UART RX FIFO, the frame decoder and the game logic.
//
// Handshake: a byte moves from the FIFO to the decoder in every cycle where
// rx_empty=0 and rd_uart=1. The decoder is always ready, so rd_uart simply
// follows !rx_empty (except during reset). r_data is only meaningful while
// rx_empty=0. frame_valid, chk_err and timeout_err are single-cycle strobes.
interface uart_rx_frame_decoder_if #(
  parameter int POS_W = 12
);
  logic             rx_empty;
  logic [7:0]       r_data;
  logic             rd_uart;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [7:0]       flags;
  logic             frame_valid;
  logic             chk_err;
  logic             timeout_err;
  logic [7:0]       frame_cnt;
  logic [7:0]       err_cnt;

  // FIFO / game-logic side
  modport master (
    output rx_empty, r_data,
    input  rd_uart, pos_x, pos_y, flags, frame_valid, chk_err, timeout_err,
           frame_cnt, err_cnt
  );

  // Decoder side
  modport slave (
    input  rx_empty, r_data,
    output rd_uart, pos_x, pos_y, flags, frame_valid, chk_err, timeout_err,
           frame_cnt, err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_decoder.sv
// UART RX frame decoder: pops bytes from the RX FIFO, hunts for the sync
// byte, assembles 7-byte position frames (SYNC XH XL YH YL FLAGS CHK),
// verifies the XOR checksum and publishes the position on registered
// outputs with a one-cycle strobe. An inter-byte timeout aborts a stalled
// frame. POS_W must be 9..16 and 2^TO_W must exceed TIMEOUT_CYCLES.
module uart_rx_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         POS_W          = 12,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter int         TO_W           = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_decoder_if.slave bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_XH   = 3'd1,
    S_XL   = 3'd2,
    S_YH   = 3'd3,
    S_YL   = 3'd4,
    S_FL   = 3'd5,
    S_CK   = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [7:0]       acc;
  logic [7:0]       x_hi, x_lo, y_hi, y_lo, fl_stage;
  logic [TO_W-1:0]  to_cnt;
  logic [POS_W-1:0] pos_x_r, pos_y_r;
  logic [7:0]       flags_r, frame_cnt_r, err_cnt_r;
  logic             fv_r, ce_r, te_r;
  logic             accept;
  logic             timeout_hit;

  // Always ready: every non-empty cycle pops a byte; nothing pops in reset.
  assign accept      = !bus.rx_empty && !rst;
  assign bus.rd_uart = accept;

  // A byte arriving on the limit cycle wins over the timeout.
  assign timeout_hit = (state != S_HUNT) && !accept && (to_cnt == TO_LIMIT);

  // Frame FSM, staging registers, checksum, timeout counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      acc         <= '0;
      x_hi        <= '0;
      x_lo        <= '0;
      y_hi        <= '0;
      y_lo        <= '0;
      fl_stage    <= '0;
      to_cnt      <= '0;
      pos_x_r     <= '0;
      pos_y_r     <= '0;
      flags_r     <= '0;
      frame_cnt_r <= '0;
      err_cnt_r   <= '0;
      fv_r        <= 1'b0;
      ce_r        <= 1'b0;
      te_r        <= 1'b0;
    end else begin
      fv_r <= 1'b0;
      ce_r <= 1'b0;
      te_r <= 1'b0;

      // Idle counter only runs while a frame is in progress.
      if (state == S_HUNT || accept) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout_hit) begin
        // Staging contents are simply abandoned; the next SYNC restarts them.
        state  <= S_HUNT;
        te_r   <= 1'b1;
        to_cnt <= '0;
        if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
      end else if (accept) begin
        case (state)
          S_HUNT: begin
            if (bus.r_data == SYNC_BYTE) begin
              state <= S_XH;
              acc   <= '0;
            end
          end
          S_XH: begin
            x_hi  <= bus.r_data;
            acc   <= acc ^ bus.r_data;
            state <= S_XL;
          end
          S_XL: begin
            x_lo  <= bus.r_data;
            acc   <= acc ^ bus.r_data;
            state <= S_YH;
          end
          S_YH: begin
            y_hi  <= bus.r_data;
            acc   <= acc ^ bus.r_data;
            state <= S_YL;
          end
          S_YL: begin
            y_lo  <= bus.r_data;
            acc   <= acc ^ bus.r_data;
            state <= S_FL;
          end
          S_FL: begin
            fl_stage <= bus.r_data;
            acc      <= acc ^ bus.r_data;
            state    <= S_CK;
          end
          S_CK: begin
            if (bus.r_data == acc) begin
              pos_x_r     <= POS_W'({x_hi, x_lo});
              pos_y_r     <= POS_W'({y_hi, y_lo});
              flags_r     <= fl_stage;
              fv_r        <= 1'b1;
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
              ce_r <= 1'b1;
              if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
            end
            state <= S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

  // Registered results onto the bus.
  assign bus.pos_x       = pos_x_r;
  assign bus.pos_y       = pos_y_r;
  assign bus.flags       = flags_r;
  assign bus.frame_valid = fv_r;
  assign bus.chk_err     = ce_r;
  assign bus.timeout_err = te_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.err_cnt     = err_cnt_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Bench for uart_rx_frame_decoder: directed and randomized byte streams,
// compared against a byte-stream reference model of the frame protocol.
module tb_uart_rx_frame_decoder;
  localparam int         POS_W = 12;
  localparam int         T     = 50;
  localparam int         TO_W  = 6;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         QW    = 2 * POS_W + 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;

  uart_rx_frame_decoder_if #(.POS_W(POS_W)) bus();

  uart_rx_frame_decoder #(
    .SYNC_BYTE(SYNC), .POS_W(POS_W), .TIMEOUT_CYCLES(T), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Works on the accepted byte stream: collects the six bytes after a SYNC,
  // counts idle cycles inside a frame, and predicts the registered outputs.
  bit               m_hunt = 1'b1;
  logic [7:0]       m_buf[$];
  int               m_idle = 0;
  logic [POS_W-1:0] m_px = '0, m_py = '0;
  logic [7:0]       m_fl = '0, m_fc = '0, m_ec = '0;
  int               exp_fv = 0, exp_ce = 0, exp_te = 0;

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] obs_q[$];
  int obs_fv = 0, obs_ce = 0, obs_te = 0, obs_multi = 0, rd_bad = 0;

  function automatic void model_step(input bit acc, input logic [7:0] b);
    logic [15:0] w;
    logic [7:0]  x;
    if (rst) begin
      m_hunt = 1'b1; m_buf.delete(); m_idle = 0;
      m_px = '0; m_py = '0; m_fl = '0; m_fc = '0; m_ec = '0;
      return;
    end
    if (m_hunt) begin
      if (acc && b == SYNC) begin
        m_hunt = 1'b0; m_idle = 0; m_buf.delete();
      end
    end else if (acc) begin
      m_idle = 0;
      m_buf.push_back(b);
      if (m_buf.size() == 6) begin
        x = m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4];
        if (x == m_buf[5]) begin
          w = {m_buf[0], m_buf[1]}; m_px = w[POS_W-1:0];
          w = {m_buf[2], m_buf[3]}; m_py = w[POS_W-1:0];
          m_fl = m_buf[4];
          m_fc = 8'((int'(m_fc) + 1) % 256);
          exp_fv++;
          exp_q.push_back({m_px, m_py, m_fl});
        end else begin
          exp_ce++;
          if (m_ec < 8'd255) m_ec = m_ec + 8'd1;
        end
        m_hunt = 1'b1; m_buf.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin
        exp_te++;
        if (m_ec < 8'd255) m_ec = m_ec + 8'd1;
        m_hunt = 1'b1; m_buf.delete(); m_idle = 0;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: present a byte (v=1) or an empty FIFO (v=0) from the
  // negedge, advance the model at the posedge and record the DUT response.
  task automatic tick(input bit v, input logic [7:0] b);
    bus.rx_empty = !v;
    bus.r_data   = v ? b : 8'($urandom);
    #1;
    if (bus.rd_uart !== (v && !rst)) rd_bad++;
    @(posedge clk);
    model_step(v && !rst, b);
    #1;
    if (bus.frame_valid === 1'b1) begin
      obs_fv++;
      obs_q.push_back({bus.pos_x, bus.pos_y, bus.flags});
    end
    if (bus.chk_err === 1'b1) obs_ce++;
    if (bus.timeout_err === 1'b1) obs_te++;
    if (int'(bus.frame_valid) + int'(bus.chk_err) + int'(bus.timeout_err) > 1) obs_multi++;
    @(negedge clk);
  endtask

  // Full frame with optional corrupted checksum and 0..maxgap idle cycles
  // before each byte after the SYNC. Returns right after the CK edge.
  task automatic send_frame(input logic [7:0] xh, xl, yh, yl, fl,
                            input bit bad, input int maxgap);
    logic [7:0] f[7];
    f[0] = SYNC; f[1] = xh; f[2] = xl; f[3] = yh; f[4] = yl; f[5] = fl;
    f[6] = xh ^ xl ^ yh ^ yl ^ fl;
    if (bad) f[6] = f[6] ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < 7; i++) begin
      if (i > 0) repeat ($urandom_range(0, maxgap)) tick(1'b0, 8'h00);
      tick(1'b1, f[i]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick(1'b1, 8'($urandom));
    checks++; if (rd_bad !== 0) begin errors++; $display("FAIL reset_rd_uart got %0d bad cycles exp 0", rd_bad); end
    checks++; if (bus.pos_x !== '0 || bus.pos_y !== '0 || bus.flags !== '0) begin errors++; $display("FAIL reset_pos got %0h/%0h/%0h exp 0", bus.pos_x, bus.pos_y, bus.flags); end
    checks++; if ({bus.frame_valid, bus.chk_err, bus.timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {bus.frame_valid, bus.chk_err, bus.timeout_err}); end
    checks++; if (bus.frame_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.frame_cnt, bus.err_cnt); end
    rst = 1'b0;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_basic();
    tick(1'b1, 8'hA5); tick(1'b1, 8'h01); tick(1'b1, 8'h2C);
    tick(1'b1, 8'h00); tick(1'b1, 8'hC8); tick(1'b1, 8'h03);
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus.frame_valid); end
    tick(1'b1, 8'hE6);
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.frame_valid); end
    checks++; if (bus.pos_x !== 12'd300 || bus.pos_y !== 12'd200 || bus.flags !== 8'h03) begin errors++; $display("FAIL basic_pos got %0d/%0d/%0h exp 300/200/3", bus.pos_x, bus.pos_y, bus.flags); end
    checks++; if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", bus.frame_cnt); end
    tick(1'b0, 8'h00);
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b exp 0", bus.frame_valid); end
  endtask

  task automatic test_chk_err();
    tick(1'b1, 8'hA5); tick(1'b1, 8'h01); tick(1'b1, 8'h2C);
    tick(1'b1, 8'h00); tick(1'b1, 8'hC8); tick(1'b1, 8'h03);
    tick(1'b1, 8'hE7);
    checks++; if (bus.chk_err !== 1'b1 || bus.frame_valid !== 1'b0) begin errors++; $display("FAIL chk_pulse got chk=%b valid=%b exp 1/0", bus.chk_err, bus.frame_valid); end
    checks++; if (bus.pos_x !== 12'd300 || bus.pos_y !== 12'd200 || bus.flags !== 8'h03) begin errors++; $display("FAIL chk_hold got %0d/%0d/%0h exp 300/200/3", bus.pos_x, bus.pos_y, bus.flags); end
    checks++; if (bus.err_cnt !== 8'd1 || bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL chk_counts got err=%0d frm=%0d exp 1/1", bus.err_cnt, bus.frame_cnt); end
    send_frame(8'h01, 8'h23, 8'h04, 8'h56, 8'h81, 1'b0, 0);
    checks++; if (bus.frame_valid !== 1'b1 || bus.pos_x !== 12'h123 || bus.pos_y !== 12'h456 || bus.flags !== 8'h81) begin errors++; $display("FAIL chk_recover got v=%b %0h/%0h/%0h exp 1 123/456/81", bus.frame_valid, bus.pos_x, bus.pos_y, bus.flags); end
  endtask

  task automatic test_gaps();
    int fv0;
    logic [7:0] junk[3];
    fv0 = obs_fv; exp_q.delete(); obs_q.delete(); rd_bad = 0;
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h12;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) tick(1'b0, 8'h00);
      tick(1'b1, junk[i]);
    end
    repeat ($urandom_range(0, 20)) tick(1'b0, 8'h00);
    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 20);
    repeat (3) tick(1'b0, 8'h00);
    checks++; if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL gaps_valid_count got %0d exp 1", obs_fv - fv0); end
    checks++; if (rd_bad !== 0) begin errors++; $display("FAIL gaps_rd_uart got %0d bad cycles exp 0", rd_bad); end
    checks++; if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL gaps_frame got %0d entries exp %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_timeout();
    int te0;
    te0 = obs_te;
    tick(1'b1, 8'hA5); tick(1'b1, 8'h01);
    repeat (T - 1) tick(1'b0, 8'h00);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", bus.timeout_err); end
    tick(1'b0, 8'h00);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b exp 1", bus.timeout_err); end
    checks++; if (bus.err_cnt !== m_ec || m_ec !== 8'd2) begin errors++; $display("FAIL timeout_err_cnt got %0d exp %0d", bus.err_cnt, m_ec); end
    send_frame(8'h0A, 8'hBC, 8'h00, 8'h7F, 8'h44, 1'b0, 3);
    checks++; if (bus.frame_valid !== 1'b1 || bus.pos_x !== 12'hABC || bus.pos_y !== 12'h07F) begin errors++; $display("FAIL timeout_recover got v=%b %0h/%0h exp 1 abc/07f", bus.frame_valid, bus.pos_x, bus.pos_y); end
    // Byte landing on the last allowed idle cycle must win.
    te0 = obs_te;
    tick(1'b1, 8'hA5);
    repeat (T - 1) tick(1'b0, 8'h00);
    tick(1'b1, 8'h01); tick(1'b1, 8'h2C); tick(1'b1, 8'h00);
    tick(1'b1, 8'hC8); tick(1'b1, 8'h03);
    repeat (T - 1) tick(1'b0, 8'h00);
    tick(1'b1, 8'hE6);
    checks++; if (obs_te - te0 !== 0 || bus.frame_valid !== 1'b1 || bus.pos_x !== 12'd300) begin errors++; $display("FAIL timeout_boundary got te=%0d v=%b x=%0d exp 0 1 300", obs_te - te0, bus.frame_valid, bus.pos_x); end
  endtask

  task automatic test_sync_in_payload();
    tick(1'b1, 8'hA5); tick(1'b1, 8'hA5); tick(1'b1, 8'h00);
    tick(1'b1, 8'h00); tick(1'b1, 8'h00); tick(1'b1, 8'h00);
    tick(1'b1, 8'hA5);
    checks++; if (bus.frame_valid !== 1'b1 || bus.pos_x !== 12'h500 || bus.pos_y !== 12'h000 || bus.flags !== 8'h00) begin errors++; $display("FAIL sync_payload got v=%b %0h/%0h/%0h exp 1 500/000/00", bus.frame_valid, bus.pos_x, bus.pos_y, bus.flags); end
  endtask

  task automatic test_random();
    exp_q.delete(); obs_q.delete();
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick(1'b1, 8'($urandom_range(0, 8'hA4)));
      if ($urandom_range(0, 7) == 0) begin
        tick(1'b1, SYNC);
        repeat ($urandom_range(0, 4)) tick(1'b1, 8'($urandom));
        repeat (T + $urandom_range(0, 5)) tick(1'b0, 8'h00);
      end else begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 0) ? 0 : 4);
      end
    end
    repeat (2) tick(1'b0, 8'h00);
    checks++; if (obs_fv !== exp_fv || obs_ce !== exp_ce || obs_te !== exp_te) begin errors++; $display("FAIL random_pulses got %0d/%0d/%0d exp %0d/%0d/%0d", obs_fv, obs_ce, obs_te, exp_fv, exp_ce, exp_te); end
    checks++; if (obs_multi !== 0) begin errors++; $display("FAIL random_exclusive got %0d overlapping cycles exp 0", obs_multi); end
    checks++; if (bus.frame_cnt !== m_fc || bus.err_cnt !== m_ec) begin errors++; $display("FAIL random_counts got %0d/%0d exp %0d/%0d", bus.frame_cnt, bus.err_cnt, m_fc, m_ec); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_frame_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [QW-1:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL random_frame got %h exp %h", o, e); end
    end
  endtask

  task automatic test_err_sat();
    for (int n = 0; n < 260; n++)
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
    tick(1'b0, 8'h00);
    checks++; if (bus.err_cnt !== 8'd255 || m_ec !== 8'd255) begin errors++; $display("FAIL err_saturate got %0d exp 255", bus.err_cnt); end
    checks++; if (bus.pos_x !== m_px || bus.pos_y !== m_py || bus.flags !== m_fl) begin errors++; $display("FAIL err_hold got %0h/%0h/%0h exp %0h/%0h/%0h", bus.pos_x, bus.pos_y, bus.flags, m_px, m_py, m_fl); end
  endtask

  task automatic test_reset_mid_and_wrap();
    rd_bad = 0;
    tick(1'b1, 8'hA5); tick(1'b1, 8'h01); tick(1'b1, 8'h2C);
    rst = 1'b1;
    tick(1'b1, 8'h00);
    checks++; if (bus.pos_x !== '0 || bus.pos_y !== '0 || bus.flags !== '0 || bus.frame_cnt !== '0 || bus.err_cnt !== '0) begin errors++; $display("FAIL midreset_outputs got %0h/%0h/%0h/%0d/%0d exp 0", bus.pos_x, bus.pos_y, bus.flags, bus.frame_cnt, bus.err_cnt); end
    rst = 1'b0;
    // The dropped frame's remaining bytes must not complete anything.
    tick(1'b1, 8'hC8); tick(1'b1, 8'h03); tick(1'b1, 8'hE6);
    send_frame(8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 1'b0, 2);
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_cnt !== 8'd1 || bus.pos_x !== 12'd300) begin errors++; $display("FAIL midreset_frame got v=%b cnt=%0d x=%0d exp 1 1 300", bus.frame_valid, bus.frame_cnt, bus.pos_x); end
    for (int n = 0; n < 255; n++)
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    checks++; if (bus.frame_cnt !== 8'd0 || m_fc !== 8'd0) begin errors++; $display("FAIL frame_cnt_wrap got %0d exp 0", bus.frame_cnt); end
    checks++; if (bus.pos_x !== m_px || bus.pos_y !== m_py || bus.flags !== m_fl) begin errors++; $display("FAIL wrap_last_frame got %0h/%0h/%0h exp %0h/%0h/%0h", bus.pos_x, bus.pos_y, bus.flags, m_px, m_py, m_fl); end
    checks++; if (rd_bad !== 0) begin errors++; $display("FAIL midreset_rd_uart got %0d bad cycles exp 0", rd_bad); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_chk_err();
    test_gaps();
    test_timeout();
    test_sync_in_payload();
    test_random();
    test_err_sat();
    test_reset_mid_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
